// File: rtl/bus_arbiter_4_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bus_arbiter_4_pkg : shared types/constants for the bus arbiter   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package bus_arbiter_4_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    localparam logic [SEL_W-1:0] REQ_FETCH = 2'd0;
    localparam logic [SEL_W-1:0] REQ_LSU   = 2'd1;
    localparam logic [SEL_W-1:0] REQ_DMA   = 2'd2;
    localparam logic [SEL_W-1:0] REQ_DBG   = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_e;

    function automatic logic [N_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_arbiter_4_rr_priority_4.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_priority_4 : first asserted request scanning ptr, ptr+1, ...  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module rr_priority_4
    import bus_arbiter_4_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic [SEL_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        idx  = ptr;
        any  = 1'b0;
        cand = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter_4.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bus_arbiter_4 : 4-way round-robin bus arbiter with burst limit   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module bus_arbiter_4
    import bus_arbiter_4_pkg::*;
#(
    parameter int MAX_BURST = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             preempt
);

    localparam int               CNT_W    = $clog2(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_e       state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic             preempt_q, preempt_d;

    logic [SEL_W-1:0] w_pick_idx;
    logic             w_pick_any;
    logic             w_owner_req;
    logic             w_owner_done;
    logic             w_others;
    logic             w_at_limit;
    logic             w_release;
    logic             w_burst_only;

    rr_priority_4 u_pick (
        .req (req),
        .ptr (ptr_q),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    // sel_q doubles as the owner index while in GRANT.
    assign w_owner_req  = req[sel_q];
    assign w_owner_done = done[sel_q];
    assign w_others     = |(req & ~onehot4(sel_q));
    assign w_at_limit   = (cnt_q == CNT_LAST);
    assign w_release    = !w_owner_req || w_owner_done || (w_at_limit && w_others);
    assign w_burst_only = w_owner_req && !w_owner_done && w_at_limit && w_others;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        busy_d    = busy_q;
        preempt_d = 1'b0;
        unique case (state_q)
            IDLE, TURN: begin
                if (w_pick_any) begin
                    state_d = GRANT;
                    gnt_d   = onehot4(w_pick_idx);
                    sel_d   = w_pick_idx;
                    cnt_d   = '0;
                    ptr_d   = w_pick_idx + 2'd1;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end
            end
            GRANT: begin
                if (w_release) begin
                    state_d   = TURN;
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    preempt_d = w_burst_only;
                end else if (w_at_limit) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            sel_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            preempt_q <= preempt_d;
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign preempt = preempt_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_4.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_bus_arbiter_4 : directed + random bench against owner model   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_bus_arbiter_4;

    localparam int MAXB = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       preempt;

    int tests;
    int fails;

    // Reference: who owns the bus, how long in the current burst window.
    int m_owner;
    int m_held;
    int m_ptr;
    int m_sel;
    bit m_pre;

    bus_arbiter_4 #(.MAX_BURST(MAXB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy),
        .preempt (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_ptr   = 0;
        m_sel   = 0;
        m_pre   = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic [3:0] d);
        bit others;
        bit lim;
        m_pre = 1'b0;
        if (m_owner >= 0) begin
            others = (r & ~(4'b0001 << m_owner)) != 4'b0000;
            lim    = (m_held == MAXB - 1);
            if (!r[m_owner] || d[m_owner] || (lim && others)) begin
                m_pre   = r[m_owner] && !d[m_owner];
                m_owner = -1;
            end else begin
                m_held = lim ? 0 : m_held + 1;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                int w;
                w = (m_ptr + k) % 4;
                if (m_owner < 0 && r[w]) begin
                    m_owner = w;
                    m_sel   = w;
                    m_held  = 0;
                    m_ptr   = (w + 1) % 4;
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0] eg;
        eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ".sel"}, 32'(sel), 32'(m_sel));
        chk({tag, ".busy"}, 32'(busy), 32'(m_owner >= 0));
        chk({tag, ".preempt"}, 32'(preempt), 32'(m_pre));
    endtask

    // One clock: inputs already applied, sample at the edge, check 1 time unit later.
    task automatic step(input string tag, input logic [3:0] r, input logic [3:0] d);
        req  = r;
        done = d;
        @(posedge clk);
        model_edge(r, d);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        logic [3:0] rv;
        logic [3:0] dv;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 4'b0000;
        model_reset();

        #12;
        check_outputs("reset");
        rst_n = 1'b1;

        // Lone requester: no preempt, cnt wraps silently.
        repeat (20) step("single", 4'b0100, 4'b0000);
        step("single_drop", 4'b0000, 4'b0000);
        step("idle", 4'b0000, 4'b0000);

        // Release by done, then rotation.
        step("rel_a", 4'b0011, 4'b0000);
        step("rel_b", 4'b0011, 4'b0000);
        step("rel_done0", 4'b0011, 4'b0001);
        repeat (3) step("rel_c", 4'b0011, 4'b0000);
        step("rel_done1", 4'b0011, 4'b0010);
        repeat (3) step("rel_d", 4'b0011, 4'b0000);
        step("rel_off", 4'b0000, 4'b0000);
        step("rel_idle", 4'b0000, 4'b0000);

        // Burst limit with two contenders.
        repeat (40) step("burst", 4'b1001, 4'b0000);
        step("burst_off", 4'b0000, 4'b0000);
        step("burst_idle", 4'b0000, 4'b0000);

        // Fairness: owner drops its request on its second cycle.
        repeat (20) begin
            rv = 4'b1111;
            if (m_owner >= 0 && m_held == 1) rv[m_owner] = 1'b0;
            step("fair", rv, 4'b0000);
        end

        // Non-owner done ignored; req drop plus done is a single release.
        repeat (3) step("ign_a", 4'b0110, 4'b0000);
        repeat (2) step("ign_nonowner", 4'b0110, 4'b1001);
        rv = 4'b0110;
        if (m_owner >= 0) rv[m_owner] = 1'b0;
        dv = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        step("ign_both", rv, dv);
        repeat (4) step("ign_b", 4'b0110, 4'b0000);

        // Random traffic with sticky requests.
        rv = 4'b0000;
        repeat (600) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(7) == 0) rv[b] = ~rv[b];
            dv = 4'b0000;
            if ($urandom_range(5) == 0) dv[$urandom_range(3)] = 1'b1;
            step("rand", rv, dv);
        end

        // Mid-burst reset: owner 1 leaves ptr at 2, reset must bring it back to 0.
        step("mid_pre", 4'b0000, 4'b0000);
        step("mid_pre", 4'b0000, 4'b0000);
        repeat (5) step("mid_burst", 4'b0010, 4'b0000);
        chk("mid_owner_before", 32'(gnt), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("mid_reset");
        req = 4'b1010;
        @(posedge clk);
        #1;
        check_outputs("mid_hold");
        rst_n = 1'b1;
        repeat (3) step("mid_after", 4'b1010, 4'b0000);
        chk("mid_after_sel", 32'(sel), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
